// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: one FIFO per functional unit, up to NUM_CDB heads granted per cycle onto
// registered CDB ports. Mispredicting branch heads win first, the rest share round-robin.
module wb_cdb_arbiter #(
  parameter int NUM_FU     = 3,
  parameter int NUM_CDB    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PREG_W     = 7,
  parameter int TAG_W      = 4,
  localparam int PKT_W     = PREG_W + 32 + 1 + 1 + TAG_W + 1 + 32 + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*PKT_W-1:0]  fu_packet,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_CDB-1:0]       cdb_valid,
  output logic [NUM_CDB*PKT_W-1:0] cdb_packet,
  output logic                     err_overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int MP_BIT = 2 + 32 + 1 + TAG_W;

  logic [PKT_W-1:0]         mem [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr [NUM_FU];
  logic [PTR_W-1:0]         wr_ptr [NUM_FU];
  logic [CNT_W-1:0]         count [NUM_FU];
  logic [PKT_W-1:0]         head [NUM_FU];
  logic [NUM_FU-1:0]        nonempty;
  logic [NUM_FU-1:0]        push;
  logic [NUM_FU-1:0]        grant;
  int                       gport [NUM_FU];
  logic [RR_W-1:0]          rr_ptr;
  logic [RR_W-1:0]          rr_next;
  logic [NUM_CDB-1:0]       port_vld;
  logic [NUM_CDB*PKT_W-1:0] port_pkt;

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      head[i]     = mem[i][rd_ptr[i]];
      nonempty[i] = (count[i] != '0);
      fu_ready[i] = !reset && (count[i] < CNT_W'(FIFO_DEPTH));
      push[i]     = fu_valid[i] && fu_ready[i];
    end
  end

  always_comb begin
    int n;
    int last;
    grant   = '0;
    rr_next = rr_ptr;
    n       = 0;
    last    = -1;
    for (int i = 0; i < NUM_FU; i++) gport[i] = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (nonempty[i] && head[i][MP_BIT] && n < NUM_CDB) begin
        grant[i] = 1'b1;
        gport[i] = n;
        n++;
      end
    end
    // Round-robin pass; the last FU granted here decides where the next scan starts.
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (i == (int'(rr_ptr) + k) % NUM_FU && nonempty[i] && !grant[i] && n < NUM_CDB) begin
          grant[i] = 1'b1;
          gport[i] = n;
          n++;
          last = i;
        end
      end
    end
    if (last >= 0) rr_next = RR_W'((last + 1) % NUM_FU);
  end

  always_comb begin
    port_vld = '0;
    port_pkt = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i] && gport[i] == p) begin
          port_vld[p]                  = 1'b1;
          port_pkt[p*PKT_W +: PKT_W] = head[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr       <= '0;
      cdb_valid    <= '0;
      cdb_packet   <= '0;
      err_overflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb_valid  <= '0;
      cdb_packet <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
        case ({push[i], grant[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: ;
        endcase
        if (fu_valid[i] && !fu_ready[i]) err_overflow <= 1'b1;
      end
      rr_ptr     <= rr_next;
      cdb_valid  <= port_vld;
      cdb_packet <= port_pkt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i] && !flush) mem[i][wr_ptr[i]] <= fu_packet[i*PKT_W +: PKT_W];
    end
  end

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Randomized bench for wb_cdb_arbiter against a queue-based model of the grant and FIFO rules.
module tb_wb_cdb_arbiter;
  localparam int NUM_FU  = 3;
  localparam int NUM_CDB = 2;
  localparam int DEPTH   = 4;
  localparam int PREG_W  = 7;
  localparam int TAG_W   = 4;
  localparam int PKT_W   = PREG_W + 32 + 1 + 1 + TAG_W + 1 + 32 + 2;
  localparam int MP_BIT  = 35 + TAG_W;
  typedef logic [PKT_W-1:0] pkt_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU*PKT_W-1:0]  fu_packet;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*PKT_W-1:0] cdb_packet;
  logic                     err_overflow;

  wb_cdb_arbiter #(
    .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .FIFO_DEPTH(DEPTH), .PREG_W(PREG_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .fu_valid(fu_valid), .fu_packet(fu_packet),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_packet(cdb_packet),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  pkt_t q [NUM_FU][$];
  int   rr_m;
  logic err_m;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic pkt_t mk_pkt(input int fu, input bit mp);
    logic [PREG_W-1:0] rd   = PREG_W'($urandom);
    logic [31:0]       val  = $urandom;
    logic [TAG_W-1:0]  tag  = TAG_W'($urandom);
    logic              bt   = 1'($urandom);
    logic [31:0]       dest = $urandom;
    return {rd, val, 1'b1, mp, tag, bt, dest, 2'(fu)};
  endfunction

  task automatic drive(input logic [NUM_FU-1:0] v, input logic [NUM_FU-1:0] mp);
    fu_valid = v;
    for (int i = 0; i < NUM_FU; i++) fu_packet[i*PKT_W +: PKT_W] = mk_pkt(i, mp[i]);
  endtask

  // One clock: check ready, predict next bus contents from the model queues, advance, compare.
  task automatic step();
    logic [NUM_FU-1:0]        rdy_m;
    int                       ports[$];
    bit                       g [NUM_FU];
    int                       last;
    logic [NUM_CDB-1:0]       nv;
    logic [NUM_CDB*PKT_W-1:0] np;
    #1;
    for (int i = 0; i < NUM_FU; i++) begin
      rdy_m[i] = !reset && (q[i].size() < DEPTH);
      g[i]     = 1'b0;
    end
    chk("fu_ready", 256'(fu_ready), 256'(rdy_m));
    for (int i = 0; i < NUM_FU; i++) begin
      if (q[i].size() > 0 && q[i][0][MP_BIT] && ports.size() < NUM_CDB) begin
        ports.push_back(i);
        g[i] = 1'b1;
      end
    end
    last = -1;
    for (int k = 0; k < NUM_FU; k++) begin
      int i;
      i = (rr_m + k) % NUM_FU;
      if (q[i].size() > 0 && !g[i] && ports.size() < NUM_CDB) begin
        ports.push_back(i);
        g[i] = 1'b1;
        last = i;
      end
    end
    nv = '0;
    np = '0;
    for (int p = 0; p < ports.size(); p++) begin
      nv[p] = 1'b1;
      np[p*PKT_W +: PKT_W] = q[ports[p]][0];
    end
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) q[i].delete();
      rr_m  = 0;
      err_m = 1'b0;
      nv    = '0;
      np    = '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) q[i].delete();
      nv = '0;
      np = '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) if (g[i]) void'(q[i].pop_front());
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i]) begin
          if (rdy_m[i]) q[i].push_back(fu_packet[i*PKT_W +: PKT_W]);
          else          err_m = 1'b1;
        end
      end
      if (last >= 0) rr_m = (last + 1) % NUM_FU;
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 256'(cdb_valid), 256'(nv));
    chk("cdb_packet", 256'(cdb_packet), 256'(np));
    chk("err_overflow", 256'(err_overflow), 256'(err_m));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    drive('0, '0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    pkt_t pk;
    pkt_t p0;
    pkt_t p2;
    n_checks = 0;
    n_errors = 0;
    rr_m     = 0;
    err_m    = 1'b0;
    reset    = 1'b1;
    flush    = 1'b0;
    drive('0, '0);

    do_reset();
    step();
    chk("ready_after_reset", 256'(fu_ready), 256'(3'b111));

    // Single packet from FU1 lands on port 0 two edges after the push.
    pk = {7'd5, 32'hDEADBEEF, 1'b1, 1'b0, 4'd3, 1'b0, 32'h0000_1000, 2'd1};
    fu_valid  = 3'b010;
    fu_packet = '0;
    fu_packet[PKT_W +: PKT_W] = pk;
    step();
    drive('0, '0);
    step();
    chk("single_valid", 256'(cdb_valid), 256'(2'b01));
    chk("single_packet", 256'(cdb_packet[PKT_W-1:0]), 256'(pk));
    step();
    chk("single_gone", 256'(cdb_valid), 256'(2'b00));

    // Mispredict priority from rr_ptr=0 with all three heads present.
    do_reset();
    drive(3'b111, 3'b100);
    p0 = fu_packet[0 +: PKT_W];
    p2 = fu_packet[2*PKT_W +: PKT_W];
    step();
    drive('0, '0);
    step();
    chk("mp_port0", 256'(cdb_packet[0 +: PKT_W]), 256'(p2));
    chk("mp_port1", 256'(cdb_packet[PKT_W +: PKT_W]), 256'(p0));
    for (int c = 0; c < 3; c++) step();

    // Round-robin with all FUs pushing for six cycles, then drain.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, '0);
      step();
    end
    drive('0, '0);
    for (int c = 0; c < 8; c++) step();

    // Flood: three in, two out per cycle must overflow within 16 cycles.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(3'b111, 3'($urandom));
      step();
    end
    chk("overflow_sticky", 256'(err_overflow), 256'(1'b1));
    drive('0, '0);
    step();
    chk("overflow_held", 256'(err_overflow), 256'(1'b1));

    // Flush with a concurrent FU0 push.
    do_reset();
    drive(3'b111, '0);
    step();
    drive(3'b011, '0);
    step();
    drive(3'b001, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive('0, '0);
    step();
    chk("flush_ready", 256'(fu_ready), 256'(3'b111));
    chk("flush_cdb", 256'(cdb_valid), 256'(2'b00));

    // Random traffic.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      flush = ($urandom_range(0, 39) == 0);
      drive(3'($urandom) | 3'($urandom), 3'($urandom) & 3'($urandom));
      step();
    end
    reset = 1'b0;
    flush = 1'b0;
    drive('0, '0);
    for (int c = 0; c < 10; c++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
